// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises external lines, keeps edge/level pending
// state and presents one fixed-priority request at a time to CP0.
module irq_ctrl #(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NSRC-1:0] irq_src,
   input  logic            we,
   input  logic [1:0]      addr,
   input  logic [31:0]     wdata,
   output logic [31:0]     rdata,
   output logic            ir_out,
   output logic [2:0]      irq_id,
   input  logic            ack,
   input  logic            eret
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      SERVICE = 2'd2
   } state_t;

   localparam logic [1:0] ADDR_MASK  = 2'd0;
   localparam logic [1:0] ADDR_PEND  = 2'd1;
   localparam logic [1:0] ADDR_EDGE  = 2'd2;
   localparam logic [1:0] ADDR_CAUSE = 2'd3;

   logic [NSRC-1:0] sync1_q, sync2_q, sync3_q;
   logic [NSRC-1:0] mask_q, mask_d;
   logic [NSRC-1:0] edgeSel_q, edgeSel_d;
   logic [NSRC-1:0] pend_q, pend_d;
   logic [31:0]     rdata_q, rdata_d;
   state_t          state_q;
   logic [2:0]      irqId_q;
   logic            irOut_q;

   logic [NSRC-1:0] pendView;
   logic [NSRC-1:0] reqVec;
   logic [NSRC-1:0] riseVec;
   logic [NSRC-1:0] w1cVec;
   logic [NSRC-1:0] idOneHot;
   logic [NSRC-1:0] ackClr;
   logic [2:0]      winnerId;
   logic            reqOfId;
   logic            unusedWdata;

   assign unusedWdata = ^wdata[31:NSRC];

   // s3 is only a history copy of s2 used for rising-edge detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         sync3_q <= '0;
      end else begin
         sync1_q <= irq_src;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Level-mode bits are taken straight from the synchroniser; the pending
   // flop only ever holds edge-mode bits.
   always_comb begin
      pendView = (pend_q & edgeSel_q) | (sync2_q & ~edgeSel_q);
      reqVec   = pendView & mask_q;
      riseVec  = sync2_q & ~sync3_q & edgeSel_q;
      w1cVec   = (we && addr == ADDR_PEND) ? wdata[NSRC-1:0] : '0;
      for (int i = 0; i < NSRC; i++) begin
         idOneHot[i] = (irqId_q == 3'(i));
      end
      ackClr  = (state_q == REQ && ack) ? idOneHot : '0;
      reqOfId = |(reqVec & idOneHot);
   end

   always_comb begin
      winnerId = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (reqVec[i]) begin
            winnerId = 3'(i);
         end
      end
   end

   // A new edge in the same cycle as a clear keeps the bit set
   always_comb begin
      pend_d    = ((pend_q & ~(w1cVec | ackClr)) | riseVec) & edgeSel_q;
      mask_d    = mask_q;
      edgeSel_d = edgeSel_q;
      if (we && addr == ADDR_MASK) begin
         mask_d = wdata[NSRC-1:0];
      end
      if (we && addr == ADDR_EDGE) begin
         edgeSel_d = wdata[NSRC-1:0];
      end
   end

   always_comb begin
      rdata_d = '0;
      case (addr)
         ADDR_MASK:  rdata_d = 32'(mask_q);
         ADDR_PEND:  rdata_d = 32'(pendView);
         ADDR_EDGE:  rdata_d = 32'(edgeSel_q);
         ADDR_CAUSE: rdata_d = {(state_q != IDLE), 20'd0, irqId_q, 6'd0, state_q};
         default:    rdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask_q    <= '0;
         edgeSel_q <= '1;
         pend_q    <= '0;
         rdata_q   <= '0;
      end else begin
         mask_q    <= mask_d;
         edgeSel_q <= edgeSel_d;
         pend_q    <= pend_d;
         rdata_q   <= rdata_d;
      end
   end

   // ack beats a withdrawn request; SERVICE only listens for eret
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         irqId_q <= '0;
         irOut_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|reqVec) begin
                  irqId_q <= winnerId;
                  state_q <= REQ;
                  irOut_q <= 1'b1;
               end
            end
            REQ: begin
               if (ack) begin
                  state_q <= SERVICE;
                  irOut_q <= 1'b0;
               end else if (!reqOfId) begin
                  state_q <= IDLE;
                  irOut_q <= 1'b0;
               end
            end
            SERVICE: begin
               if (eret) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               irOut_q <= 1'b0;
            end
         endcase
      end
   end

   assign rdata  = rdata_q;
   assign ir_out = irOut_q;
   assign irq_id = irqId_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: a cycle model checked every cycle plus directed
// scenarios with hand-computed expectations.
module tb_irq_ctrl;

   localparam int NSRC = 8;

   logic            clk;
   logic            rst;
   logic [NSRC-1:0] irq_src;
   logic            we;
   logic [1:0]      addr;
   logic [31:0]     wdata;
   logic [31:0]     rdata;
   logic            ir_out;
   logic [2:0]      irq_id;
   logic            ack;
   logic            eret;

   int checks   = 0;
   int failures = 0;

   irq_ctrl #(.NSRC(NSRC)) dut (
      .clk     (clk),
      .rst     (rst),
      .irq_src (irq_src),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .rdata   (rdata),
      .ir_out  (ir_out),
      .irq_id  (irq_id),
      .ack     (ack),
      .eret    (eret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model state: three sample stages of the raw lines, registers, and the
   // handshake phase (0 idle, 1 requesting, 2 in handler).
   logic [7:0]  mS1, mS2, mS3, mMask, mEdge, mPend;
   int          mState;
   logic [2:0]  mId;
   logic [31:0] mRdata;
   logic [7:0]  pv, rv, clr, nextPend;
   logic [2:0]  nextId;
   int          nextState;

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            mS1 = '0; mS2 = '0; mS3 = '0;
            mMask = 8'h00; mEdge = 8'hFF; mPend = 8'h00;
            mState = 0; mId = '0; mRdata = '0;
         end else begin
            pv = (mPend & mEdge) | (mS2 & ~mEdge);
            rv = pv & mMask;
            case (addr)
               2'd0:    mRdata = {24'h0, mMask};
               2'd1:    mRdata = {24'h0, pv};
               2'd2:    mRdata = {24'h0, mEdge};
               default: mRdata = {(mState != 0), 20'h0, mId, 6'h0, 2'(mState)};
            endcase
            clr = (we && addr == 2'd1) ? wdata[7:0] : 8'h00;
            if (mState == 1 && ack) clr[mId] = 1'b1;
            nextPend  = ((mPend & ~clr) | (mS2 & ~mS3)) & mEdge;
            nextState = mState;
            nextId    = mId;
            if (mState == 0 && rv != 0) begin
               for (int i = 7; i >= 0; i--) if (rv[i]) nextId = 3'(i);
               nextState = 1;
            end else if (mState == 1) begin
               if (ack) nextState = 2;
               else if (!rv[mId]) nextState = 0;
            end else if (mState == 2 && eret) begin
               nextState = 0;
            end
            if (we && addr == 2'd0) mMask = wdata[7:0];
            if (we && addr == 2'd2) mEdge = wdata[7:0];
            mPend  = nextPend;
            mState = nextState;
            mId    = nextId;
            mS3 = mS2; mS2 = mS1; mS1 = irq_src;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         checkOutput("cyc_ir_out", {31'd0, ir_out}, {31'd0, (mState == 1)});
         checkOutput("cyc_irq_id", {29'd0, irq_id}, {29'd0, mId});
         checkOutput("cyc_rdata", rdata, mRdata);
      end
   end

   task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d,
                                input logic k, input logic e);
      we = w; addr = a; wdata = d; ack = k; eret = e;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #3;
   endtask

   task automatic writeReg(input logic [1:0] a, input logic [31:0] d);
      applyStimulus(1'b1, a, d, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, a, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      irq_src = '0;
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
      tick(2);
      checkOutput("rst_ir_out", {31'd0, ir_out}, 32'h0);
      checkOutput("rst_irq_id", {29'd0, irq_id}, 32'h0);
      checkOutput("rst_rdata", rdata, 32'h0);
      rst = 1'b1;
      applyStimulus(1'b0, 2'd2, 32'h0, 1'b0, 1'b0);
      tick(1);
      checkOutput("rst_edge_sel", rdata, 32'h0000_00FF);

      // Single edge source, MASK=0x05
      writeReg(2'd0, 32'h05);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      irq_src = 8'h04;
      tick(2);
      irq_src = 8'h00;
      tick(1);
      checkOutput("s1_ir_out_n2", {31'd0, ir_out}, 32'h0);
      tick(1);
      checkOutput("s1_ir_out_n3", {31'd0, ir_out}, 32'h1);
      checkOutput("s1_irq_id", {29'd0, irq_id}, 32'd2);
      checkOutput("s1_pending", rdata, 32'h04);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      checkOutput("s1_ack_ir_out", {31'd0, ir_out}, 32'h0);
      tick(1);
      checkOutput("s1_ack_pending", rdata, 32'h00);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      tick(1);

      // Two simultaneous edges: priority then deferred request
      writeReg(2'd0, 32'hFF);
      irq_src = 8'h28;
      tick(4);
      irq_src = 8'h00;
      checkOutput("s2_first_id", {29'd0, irq_id}, 32'd3);
      checkOutput("s2_first_ir", {31'd0, ir_out}, 32'h1);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
      checkOutput("s2_after_eret", {31'd0, ir_out}, 32'h0);
      tick(1);
      checkOutput("s2_second_ir", {31'd0, ir_out}, 32'h1);
      checkOutput("s2_second_id", {29'd0, irq_id}, 32'd5);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
      tick(1);

      // Withdrawal by masking, then mask+ack together
      writeReg(2'd0, 32'h10);
      irq_src = 8'h10;
      tick(4);
      irq_src = 8'h00;
      checkOutput("s3_req_id", {29'd0, irq_id}, 32'd4);
      writeReg(2'd0, 32'h00);
      tick(1);
      checkOutput("s3_withdrawn", {31'd0, ir_out}, 32'h0);
      writeReg(2'd0, 32'h10);
      tick(1);
      checkOutput("s3_rereq", {31'd0, ir_out}, 32'h1);
      applyStimulus(1'b1, 2'd0, 32'h0, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b0, 2'd3, 32'h0, 1'b0, 1'b0);
      checkOutput("s3_ack_wins", {31'd0, ir_out}, 32'h0);
      tick(1);
      checkOutput("s3_cause_service", rdata, 32'h8000_0402);
      applyStimulus(1'b0, 2'd3, 32'h0, 1'b0, 1'b1);
      tick(1);
      writeReg(2'd3, 32'hFFFF_FFFF);
      tick(1);
      checkOutput("s3_cause_idle", rdata, 32'h0000_0400);

      // Level mode on source 1
      writeReg(2'd2, 32'h00);
      writeReg(2'd0, 32'h02);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      irq_src = 8'h02;
      tick(3);
      checkOutput("s4_level_ir", {31'd0, ir_out}, 32'h1);
      checkOutput("s4_level_id", {29'd0, irq_id}, 32'd1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      tick(1);
      checkOutput("s4_level_again", {31'd0, ir_out}, 32'h1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b1, 2'd1, 32'h02, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      tick(1);
      checkOutput("s4_w1c_ignored", rdata, 32'h02);
      irq_src = 8'h00;
      tick(3);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b1);
      tick(1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      checkOutput("s4_fallen_ir", {31'd0, ir_out}, 32'h0);
      tick(1);
      checkOutput("s4_fallen_ir2", {31'd0, ir_out}, 32'h0);
      checkOutput("s4_fallen_pend", rdata, 32'h00);
      writeReg(2'd2, 32'hFF);

      // Edge coincident with W1C, then async reset in SERVICE and REQ
      writeReg(2'd0, 32'h01);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      irq_src = 8'h01;
      tick(2);
      applyStimulus(1'b1, 2'd1, 32'h01, 1'b0, 1'b0);
      tick(1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      tick(1);
      checkOutput("s5_set_wins", rdata, 32'h01);
      checkOutput("s5_req_id0", {31'd0, ir_out}, 32'h1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b1, 1'b0);
      tick(1);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      #1 rst = 1'b0;
      irq_src = 8'h00;
      #1;
      checkOutput("s5_rst_ir_out", {31'd0, ir_out}, 32'h0);
      checkOutput("s5_rst_rdata", rdata, 32'h0);
      tick(1);
      rst = 1'b1;
      applyStimulus(1'b0, 2'd3, 32'h0, 1'b0, 1'b0);
      tick(1);
      checkOutput("s5_cause_zero", rdata, 32'h0);
      applyStimulus(1'b0, 2'd1, 32'h0, 1'b0, 1'b0);
      tick(1);
      checkOutput("s5_pend_zero", rdata, 32'h0);
      writeReg(2'd0, 32'h01);
      irq_src = 8'h01;
      tick(4);
      checkOutput("s5_req_again", {31'd0, ir_out}, 32'h1);
      #1 rst = 1'b0;
      #1;
      checkOutput("s5_async_drop", {31'd0, ir_out}, 32'h0);
      irq_src = 8'h00;
      tick(1);
      rst = 1'b1;
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
